// File: rtl/bp_nonsynth_commit_watchdog.sv
// Commit-aware simulation supervisor: watches per-core commit/finish streams and
// issues a sticky pass / stall-timeout / cycle-timeout verdict.
module bp_nonsynth_commit_watchdog #(
  parameter int core_els_p    = 1,
  parameter int vaddr_width_p = 39,
  parameter int cnt_width_p   = 32,
  parameter int stall_limit_p = 4096,
  parameter int cycle_limit_p = 1000000,
  localparam int id_width_lp  = (core_els_p > 1) ? $clog2(core_els_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 en_i,
  input  logic [core_els_p-1:0]                commit_v_i,
  input  logic [core_els_p*vaddr_width_p-1:0]  commit_pc_i,
  input  logic [core_els_p-1:0]                finish_v_i,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 stall_timeout_o,
  output logic                                 cycle_timeout_o,
  output logic [id_width_lp-1:0]               stall_core_id_o,
  output logic [vaddr_width_p-1:0]             stall_pc_o,
  output logic [cnt_width_p-1:0]               cycle_cnt_o,
  output logic [core_els_p*cnt_width_p-1:0]    commit_cnt_o
);

  localparam int stall_width_lp = $clog2(stall_limit_p + 1);
  localparam logic [1:0] e_idle = 2'd0;
  localparam logic [1:0] e_run  = 2'd1;
  localparam logic [1:0] e_done = 2'd2;
  localparam logic [stall_width_lp-1:0] stall_max_lp = stall_width_lp'(stall_limit_p);
  localparam logic [cnt_width_p-1:0]    cycle_max_lp = cnt_width_p'(cycle_limit_p);

  function automatic logic [cnt_width_p-1:0] sat_inc_cnt(input logic [cnt_width_p-1:0] v);
    if (&v) return v;
    else    return v + cnt_width_p'(1);
  endfunction

  function automatic logic [stall_width_lp-1:0] sat_inc_stall(input logic [stall_width_lp-1:0] v);
    if (v == stall_max_lp) return stall_max_lp;
    else                   return v + stall_width_lp'(1);
  endfunction

  logic [1:0]                                r_state;
  logic [cnt_width_p-1:0]                    r_cycle_cnt;
  logic [core_els_p-1:0][cnt_width_p-1:0]    r_commit_cnt;
  logic [core_els_p-1:0][vaddr_width_p-1:0]  r_last_pc;
  logic [core_els_p-1:0][stall_width_lp-1:0] r_stall_cnt;
  logic [core_els_p-1:0]                     r_finished;
  logic                                      r_done, r_pass, r_stall_to, r_cycle_to;
  logic [id_width_lp-1:0]                    r_stall_id;
  logic [vaddr_width_p-1:0]                  r_stall_pc;

  logic                                      w_counting;
  logic [cnt_width_p-1:0]                    w_cycle_cnt_n;
  logic [core_els_p-1:0][cnt_width_p-1:0]    w_commit_cnt_n;
  logic [core_els_p-1:0][vaddr_width_p-1:0]  w_last_pc_n;
  logic [core_els_p-1:0][stall_width_lp-1:0] w_stall_cnt_n;
  logic [core_els_p-1:0]                     w_finished_n;
  logic [core_els_p-1:0]                     w_stall_hit;
  logic                                      w_all_fin, w_any_stall, w_cyc_hit, w_verdict;
  logic [id_width_lp-1:0]                    w_stall_id;

  // Next-state counters and verdict detection; idle counts too so the first enabled edge yields cycle 1
  always_comb begin
    case (r_state)
      e_idle, e_run: w_counting = en_i;
      default:       w_counting = 1'b0;
    endcase
    w_cycle_cnt_n = r_cycle_cnt + cnt_width_p'(1);
    w_finished_n  = r_finished | finish_v_i;
    for (int i = 0; i < core_els_p; i++) begin
      if (commit_v_i[i]) begin
        w_commit_cnt_n[i] = sat_inc_cnt(r_commit_cnt[i]);
        w_last_pc_n[i]    = commit_pc_i[i*vaddr_width_p +: vaddr_width_p];
      end else begin
        w_commit_cnt_n[i] = r_commit_cnt[i];
        w_last_pc_n[i]    = r_last_pc[i];
      end
      if (commit_v_i[i] || w_finished_n[i]) w_stall_cnt_n[i] = '0;
      else                                  w_stall_cnt_n[i] = sat_inc_stall(r_stall_cnt[i]);
      w_stall_hit[i] = (w_stall_cnt_n[i] == stall_max_lp);
    end
    // Descending scan so the lowest stalled index is the one that sticks
    w_stall_id = '0;
    for (int i = core_els_p - 1; i >= 0; i--) begin
      w_stall_id = w_stall_hit[i] ? id_width_lp'(i) : w_stall_id;
    end
    w_all_fin   = &w_finished_n;
    w_any_stall = |w_stall_hit;
    w_cyc_hit   = (w_cycle_cnt_n == cycle_max_lp);
    w_verdict   = w_all_fin | w_any_stall | w_cyc_hit;
  end

  // State, counters and the registered sticky verdict
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= e_idle;
      r_cycle_cnt  <= '0;
      r_commit_cnt <= '0;
      r_last_pc    <= '0;
      r_stall_cnt  <= '0;
      r_finished   <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_stall_to   <= 1'b0;
      r_cycle_to   <= 1'b0;
      r_stall_id   <= '0;
      r_stall_pc   <= '0;
    end else begin
      case (r_state)
        e_idle, e_run: begin
          if (w_counting) begin
            r_cycle_cnt  <= w_cycle_cnt_n;
            r_commit_cnt <= w_commit_cnt_n;
            r_last_pc    <= w_last_pc_n;
            r_stall_cnt  <= w_stall_cnt_n;
            r_finished   <= w_finished_n;
            if (w_verdict) begin
              r_state    <= e_done;
              r_done     <= 1'b1;
              r_pass     <= w_all_fin;
              r_stall_to <= ~w_all_fin & w_any_stall;
              r_cycle_to <= ~w_all_fin & ~w_any_stall;
              if (!w_all_fin && w_any_stall) begin
                r_stall_id <= w_stall_id;
                r_stall_pc <= r_last_pc[w_stall_id];
              end else begin
                r_stall_id <= '0;
                r_stall_pc <= '0;
              end
            end else begin
              r_state <= e_run;
            end
          end else begin
            r_state <= r_state;
          end
        end
        e_done:  r_state <= e_done;
        default: r_state <= e_idle;
      endcase
    end
  end

  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign stall_timeout_o = r_stall_to;
  assign cycle_timeout_o = r_cycle_to;
  assign stall_core_id_o = r_stall_id;
  assign stall_pc_o      = r_stall_pc;
  assign cycle_cnt_o     = r_cycle_cnt;
  assign commit_cnt_o    = r_commit_cnt;

endmodule

// File: tb/tb_bp_nonsynth_commit_watchdog.sv
// Directed bench for bp_nonsynth_commit_watchdog: three cores, stall limit 8, cycle budget 100.
module tb_bp_nonsynth_commit_watchdog;
  localparam int CORES = 3;
  localparam int VW    = 39;
  localparam int CW    = 32;
  localparam int SL    = 8;
  localparam int CL    = 100;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic                  en_i;
  logic [CORES-1:0]      commit_v_i;
  logic [CORES*VW-1:0]   commit_pc_i;
  logic [CORES-1:0]      finish_v_i;
  logic                  done_o, pass_o, stall_timeout_o, cycle_timeout_o;
  logic [1:0]            stall_core_id_o;
  logic [VW-1:0]         stall_pc_o;
  logic [CW-1:0]         cycle_cnt_o;
  logic [CORES*CW-1:0]   commit_cnt_o;

  int n_total = 0;
  int n_bad   = 0;

  bp_nonsynth_commit_watchdog #(
    .core_els_p(CORES), .vaddr_width_p(VW), .cnt_width_p(CW),
    .stall_limit_p(SL), .cycle_limit_p(CL)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .finish_v_i(finish_v_i),
    .done_o(done_o), .pass_o(pass_o),
    .stall_timeout_o(stall_timeout_o), .cycle_timeout_o(cycle_timeout_o),
    .stall_core_id_o(stall_core_id_o), .stall_pc_o(stall_pc_o),
    .cycle_cnt_o(cycle_cnt_o), .commit_cnt_o(commit_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] ccnt(input int k);
    return commit_cnt_o[k*CW +: CW];
  endfunction

  task automatic step(input logic e, input logic [CORES-1:0] c, input logic [CORES-1:0] f);
    en_i = e; commit_v_i = c; finish_v_i = f;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    en_i = 1'b0; commit_v_i = '0; finish_v_i = '0; commit_pc_i = '0;
    @(negedge clk);
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_i = 1'b1; en_i = 1'b0; commit_v_i = '0; finish_v_i = '0; commit_pc_i = '0;
    apply_reset();
    chk("rst_done",   done_o, 0);
    chk("rst_pass",   pass_o, 0);
    chk("rst_stall",  stall_timeout_o, 0);
    chk("rst_cyc",    cycle_timeout_o, 0);
    chk("rst_cycnt",  cycle_cnt_o, 0);
    chk("rst_commit", commit_cnt_o == '0, 1);

    // Pass: core2 finishes at cycle 1, core0 at 20, core1 at 30
    for (int c = 1; c <= 30; c++) begin
      step(1'b1, 3'b011, (c == 1) ? 3'b100 : (c == 20) ? 3'b001 : (c == 30) ? 3'b010 : 3'b000);
      if (c == 29) chk("t1_not_yet", done_o, 0);
    end
    chk("t1_done",  done_o, 1);
    chk("t1_pass",  pass_o, 1);
    chk("t1_stall", stall_timeout_o, 0);
    chk("t1_cyc",   cycle_timeout_o, 0);
    chk("t1_cycnt", cycle_cnt_o, 30);
    chk("t1_cc0",   ccnt(0), 30);
    chk("t1_cc2",   ccnt(2), 0);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b011, 3'b000);
    chk("t1_frozen_cyc", cycle_cnt_o, 30);
    chk("t1_frozen_cc1", ccnt(1), 30);

    // Stall: core1 commits 0x80000040 only at cycle 5
    apply_reset();
    for (int c = 1; c <= 13; c++) begin
      commit_pc_i[0 +: VW]  = 39'h1000 + 39'(c * 4);
      commit_pc_i[VW +: VW] = (c == 5) ? 39'h80000040 : 39'h0;
      step(1'b1, {1'b0, (c == 5), 1'b1}, (c == 1) ? 3'b100 : 3'b000);
      if (c == 12) chk("t2_not_yet", done_o, 0);
    end
    chk("t2_done",  done_o, 1);
    chk("t2_stall", stall_timeout_o, 1);
    chk("t2_pass",  pass_o, 0);
    chk("t2_cyc",   cycle_timeout_o, 0);
    chk("t2_id",    stall_core_id_o, 1);
    chk("t2_pc",    stall_pc_o, 39'h80000040);
    chk("t2_cycnt", cycle_cnt_o, 13);
    chk("t2_cc1",   ccnt(1), 1);

    // Cycle budget
    apply_reset();
    for (int c = 1; c <= 100; c++) begin
      step(1'b1, 3'b111, 3'b000);
      if (c == 99) chk("t3_not_yet", done_o, 0);
    end
    chk("t3_done",  done_o, 1);
    chk("t3_cyc",   cycle_timeout_o, 1);
    chk("t3_pass",  pass_o, 0);
    chk("t3_stall", stall_timeout_o, 0);
    chk("t3_cycnt", cycle_cnt_o, 100);
    chk("t3_cc2",   ccnt(2), 100);

    // Final finish on the budget cycle resolves to pass; commits after finish still count
    apply_reset();
    for (int c = 1; c <= 100; c++)
      step(1'b1, 3'b011, (c == 1) ? 3'b100 : (c == 50) ? 3'b001 : (c == 100) ? 3'b010 : 3'b000);
    chk("t4a_pass",  pass_o, 1);
    chk("t4a_cyc",   cycle_timeout_o, 0);
    chk("t4a_cycnt", cycle_cnt_o, 100);
    chk("t4a_cc0",   ccnt(0), 100);

    // Cores 0 and 2 stall together: lowest index, never-committed PC is 0
    apply_reset();
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, 3'b010, 3'b000);
      if (c == 7) chk("t4b_not_yet", done_o, 0);
    end
    chk("t4b_stall", stall_timeout_o, 1);
    chk("t4b_id",    stall_core_id_o, 0);
    chk("t4b_pc",    stall_pc_o, 0);
    chk("t4b_cycnt", cycle_cnt_o, 8);

    // Pause: 50 disabled cycles with an ignored commit and finish
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      commit_pc_i[0 +: VW] = 39'h2000 + 39'(c * 4);
      step(1'b1, 3'b011, (c == 1) ? 3'b100 : 3'b000);
    end
    commit_pc_i[0 +: VW] = 39'h7777;
    for (int k = 0; k < 50; k++)
      step(1'b0, (k == 10) ? 3'b001 : 3'b000, (k == 20) ? 3'b010 : 3'b000);
    chk("t5_pause_cyc",  cycle_cnt_o, 3);
    chk("t5_pause_cc0",  ccnt(0), 3);
    chk("t5_pause_done", done_o, 0);
    for (int c = 4; c <= 11; c++) begin
      step(1'b1, 3'b000, 3'b000);
      if (c == 10) chk("t5_not_yet", done_o, 0);
    end
    chk("t5_stall", stall_timeout_o, 1);
    chk("t5_id",    stall_core_id_o, 0);
    chk("t5_pc",    stall_pc_o, 39'h200C);
    chk("t5_cycnt", cycle_cnt_o, 11);

    // Asynchronous reset between edges after the stall verdict
    @(posedge clk); #3;
    reset_i = 1'b1;
    #1;
    chk("t6_done",  done_o, 0);
    chk("t6_stall", stall_timeout_o, 0);
    chk("t6_id",    stall_core_id_o, 0);
    chk("t6_pc",    stall_pc_o, 0);
    chk("t6_cycnt", cycle_cnt_o, 0);
    chk("t6_cc",    commit_cnt_o == '0, 1);
    #2;
    reset_i = 1'b0;
    step(1'b1, 3'b000, 3'b100);
    chk("t6_restart_cyc",  cycle_cnt_o, 1);
    chk("t6_restart_done", done_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
